// File: rtl/vme_master_pkg.sv
// vme_master_pkg
// Shared definitions for the VME bus master: the transaction state
// encoding, the default A24 address modifier, the data pattern returned
// on any failed command, and the width of the per-state timeout counter.
// No ports; imported by vme_master.

package vme_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    // A24 non-privileged data access
    localparam logic [5:0] AM_CODE_DEFAULT = 6'h39;

    // Read data reported for timeouts, bus errors and illegal commands
    localparam logic [15:0] ERR_FILL = 16'hFFFF;

    // Width of the saturating per-state cycle counter
    localparam int unsigned TMO_W = 10;

endpackage

// File: rtl/vme_sync2.sv
// vme_sync2
// Two-flop synchroniser for an asynchronous active-low slave response.
// Both flops reset to 1 so a reset never looks like an asserted response.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   d    in   asynchronous input
//   q    out  synchronised output, two cycles of latency

module vme_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vme_master.sv
// vme_master
// Single-transaction A24/D16 VME bus master. A one-cycle command from the
// test controller launches one read or write; the master drives address,
// AM and WRITE for a setup period, asserts AS/DS, waits for DTACK or BERR
// (with timeout), releases the strobes, waits for the slave to release,
// and finally pulses a completion strobe back to the controller.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   vme_cmd                   one-cycle start pulse
//   vme_addr, vme_wr, vme_rd, vme_wr_data   command, sampled with vme_cmd
//   vme_cmd_rd                one-cycle completion pulse
//   vme_rd_data, vme_err      read data and error status of last command
//   busy                      command in progress
//   vme_a, vme_am, vme_as_n, vme_write_n, vme_ds_n   backplane control
//   vme_d_out, vme_d_oe, vme_d_in                    backplane data
//   vme_dtack_n, vme_berr_n   asynchronous slave responses

module vme_master
    import vme_master_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter logic [5:0]  AM_CODE     = AM_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vme_cmd,
    input  logic [22:0] vme_addr,
    input  logic        vme_wr,
    input  logic        vme_rd,
    input  logic [15:0] vme_wr_data,
    output logic        vme_cmd_rd,
    output logic [15:0] vme_rd_data,
    output logic        vme_err,
    output logic        busy,
    output logic [22:0] vme_a,
    output logic [5:0]  vme_am,
    output logic        vme_as_n,
    output logic        vme_write_n,
    output logic [1:0]  vme_ds_n,
    output logic [15:0] vme_d_out,
    output logic        vme_d_oe,
    input  logic [15:0] vme_d_in,
    input  logic        vme_dtack_n,
    input  logic        vme_berr_n
);

    // Counter values on which SETUP and the wait states end; the counter
    // reads 0 in the first cycle of each state.
    localparam logic [TMO_W-1:0] SETUP_LAST = TMO_W'(SETUP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            next_state;
    logic [TMO_W-1:0]  cnt;
    logic              dtack_s;
    logic              berr_s;
    logic              lat_wr;

    logic              nx_wr;
    logic              nx_err;
    logic [15:0]       nx_rd_data;
    logic [22:0]       nx_a;
    logic [15:0]       nx_d_out;

    vme_sync2 u_sync_dtack (
        .clk (clk),
        .rst (rst),
        .d   (vme_dtack_n),
        .q   (dtack_s)
    );

    vme_sync2 u_sync_berr (
        .clk (clk),
        .rst (rst),
        .d   (vme_berr_n),
        .q   (berr_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the next values of the latched command and the
    // status returned to the controller. BERR is tested before DTACK so a
    // simultaneous arrival reports an error.
    always_comb begin
        next_state = state;
        nx_wr      = lat_wr;
        nx_err     = vme_err;
        nx_rd_data = vme_rd_data;
        nx_a       = vme_a;
        nx_d_out   = vme_d_out;

        case (state)
            IDLE: begin
                if (vme_cmd) begin
                    nx_err = 1'b0;
                    if (vme_wr ^ vme_rd) begin
                        next_state = SETUP;
                        nx_wr      = vme_wr;
                        nx_a       = vme_addr;
                        nx_d_out   = vme_wr_data;
                    end else begin
                        next_state = DONE;
                        nx_err     = 1'b1;
                        nx_rd_data = ERR_FILL;
                    end
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                if (!berr_s) begin
                    next_state = RELEASE;
                    nx_err     = 1'b1;
                    nx_rd_data = ERR_FILL;
                end else if (!dtack_s) begin
                    next_state = RELEASE;
                    if (!lat_wr) begin
                        nx_rd_data = vme_d_in;
                    end
                end else if (cnt == TMO_LAST) begin
                    next_state = RELEASE;
                    nx_err     = 1'b1;
                    nx_rd_data = ERR_FILL;
                end
            end
            RELEASE: begin
                // A stuck slave response only ends the wait, it is not an error.
                if ((dtack_s && berr_s) || (cnt == TMO_LAST)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Per-state cycle counter: restarts on every state change, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered outputs, decoded from the state being entered so that
    // the pins change in the same cycle the state does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr      <= 1'b0;
            vme_err     <= 1'b0;
            vme_rd_data <= '0;
            vme_a       <= '0;
            vme_d_out   <= '0;
            vme_am      <= AM_CODE;
            vme_as_n    <= 1'b1;
            vme_ds_n    <= 2'b11;
            vme_write_n <= 1'b1;
            vme_d_oe    <= 1'b0;
            vme_cmd_rd  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lat_wr      <= nx_wr;
            vme_err     <= nx_err;
            vme_rd_data <= nx_rd_data;
            vme_a       <= nx_a;
            vme_d_out   <= nx_d_out;
            vme_am      <= AM_CODE;
            vme_as_n    <= (next_state != STROBE);
            vme_ds_n    <= (next_state == STROBE) ? 2'b00 : 2'b11;
            vme_write_n <= !(nx_wr && (next_state inside {SETUP, STROBE, RELEASE}));
            vme_d_oe    <= nx_wr && (next_state inside {SETUP, STROBE});
            vme_cmd_rd  <= (next_state == DONE);
            busy        <= (next_state != IDLE);
        end
    end

endmodule
